// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states,
// clear-sequencer FSM states and the tag-width helper.
package bp_pkg;

    localparam logic [1:0] CTR_SNT  = 2'b00;
    localparam logic [1:0] CTR_WNT  = 2'b01;
    localparam logic [1:0] CTR_WT   = 2'b10;
    localparam logic [1:0] CTR_ST   = 2'b11;
    localparam logic [1:0] CTR_INIT = CTR_WT;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bp_state_e;

    // Tag covers every PC bit above the index and the 2-bit word offset.
    function automatic int tag_bits(input int xlen, input int idx_w);
        return xlen - idx_w - 2;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Next value of a 2-bit saturating taken/not-taken counter.
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target table with 2-bit counters, EX-stage redirect
// logic, entry-by-entry clear sequencer and saturating perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    input  logic            br_valid_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] target_e,
    input  logic            taken_e,
    input  logic            pred_taken_e,
    input  logic [XLEN-1:0] pred_target_e,
    output logic            mispredict_e,
    output logic [XLEN-1:0] redirect_pc_e,
    output logic            flush_d,
    output logic            flush_e,
    input  logic            clear_req,
    output logic            busy,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = tag_bits(XLEN, IDX_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    bp_state_e          r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [31:0]        r_br_count, r_mispred_count;

    logic [IDX_W-1:0]   w_idx_f, w_idx_e;
    logic [TAG_W-1:0]   w_tag_f, w_tag_e;
    logic               w_hit_f, w_hit_e, w_do_upd;
    logic [1:0]         w_ctr_nxt;
    logic               w_unused;

    assign w_unused = ^{pc_f[1:0], pc_e[1:0]};

    assign w_idx_f = pc_f[IDX_W+1:2];
    assign w_tag_f = pc_f[XLEN-1:IDX_W+2];
    assign w_idx_e = pc_e[IDX_W+1:2];
    assign w_tag_e = pc_e[XLEN-1:IDX_W+2];

    assign busy     = (r_state == ST_CLEAR);
    assign w_hit_f  = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign w_hit_e  = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
    assign w_do_upd = br_valid_e && (r_state == ST_IDLE);

    assign pred_taken_f  = w_hit_f && r_ctr[w_idx_f][1] && !busy;
    assign pred_target_f = w_hit_f ? r_target[w_idx_f] : '0;

    assign mispredict_e  = br_valid_e &&
                           ((taken_e != pred_taken_e) ||
                            (taken_e && (target_e != pred_target_e)));
    assign redirect_pc_e = taken_e ? target_e : pc_e + XLEN'(4);
    assign flush_d       = mispredict_e;
    assign flush_e       = mispredict_e;

    sat_ctr2 u_sat_ctr2 (
        .i_ctr   (r_ctr[w_idx_e]),
        .i_taken (taken_e),
        .o_ctr   (w_ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_SNT;
        end else if (r_state == ST_CLEAR) begin
            r_valid[r_ptr] <= 1'b0;
        end else if (br_valid_e) begin
            if (w_hit_e) begin
                r_ctr[w_idx_e] <= w_ctr_nxt;
            end else if (taken_e) begin
                r_valid[w_idx_e] <= 1'b1;
                r_ctr[w_idx_e]   <= CTR_INIT;
            end
        end
    end

    // Tag/target carry no reset; the valid bit gates their use. On a taken
    // hit the tag rewrite is a no-op, so hit and allocate share one path.
    always_ff @(posedge clk) begin
        if (rst_n && w_do_upd && taken_e) begin
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= target_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (br_valid_e && (r_br_count != '1)) r_br_count <= r_br_count + 32'd1;
            if (mispredict_e && (r_mispred_count != '1))
                r_mispred_count <= r_mispred_count + 32'd1;
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations are queued as stimulus
// is driven and popped when the corresponding output is observed.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        br_valid_e;
    logic [31:0] pc_e, target_e, pred_target_e;
    logic        taken_e, pred_taken_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic        flush_d, flush_e;
    logic        clear_req;
    logic        busy;
    logic [31:0] br_count, mispred_count;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned mdl_br = 0;
    int unsigned mdl_mis = 0;
    int          n_busy;

    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_f          (pc_f),
        .pred_taken_f  (pred_taken_f),
        .pred_target_f (pred_target_f),
        .br_valid_e    (br_valid_e),
        .pc_e          (pc_e),
        .target_e      (target_e),
        .taken_e       (taken_e),
        .pred_taken_e  (pred_taken_e),
        .pred_target_e (pred_target_e),
        .mispredict_e  (mispredict_e),
        .redirect_pc_e (redirect_pc_e),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .clear_req     (clear_req),
        .busy          (busy),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_item_t it;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: got %h expected queued entry", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                miscompares++;
                $error("FAIL %s: got %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
        pc_f = pc;
        push($sformatf("pred_taken@%h", pc), {31'd0, exp_tk});
        push($sformatf("pred_target@%h", pc), exp_tgt);
        #1;
        chk({31'd0, pred_taken_f});
        chk(pred_target_f);
    endtask

    task automatic counters();
        push("busy", 32'd0);
        push("br_count", mdl_br);
        push("mispred_count", mdl_mis);
        #1;
        chk({31'd0, busy});
        chk(br_count);
        chk(mispred_count);
    endtask

    // Resolve one branch in EX; checks redirect outputs, then advances one edge.
    task automatic br(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                      input logic ptk, input logic [31:0] ptgt);
        logic m;
        m = (tk != ptk) || (tk && (tgt != ptgt));
        br_valid_e = 1'b1;
        pc_e = pc; target_e = tgt; taken_e = tk;
        pred_taken_e = ptk; pred_target_e = ptgt;
        push("mispredict_e", {31'd0, m});
        push("redirect_pc_e", tk ? tgt : pc + 32'd4);
        push("flush_d", {31'd0, m});
        push("flush_e", {31'd0, m});
        #1;
        chk({31'd0, mispredict_e});
        chk(redirect_pc_e);
        chk({31'd0, flush_d});
        chk({31'd0, flush_e});
        mdl_br++;
        if (m) mdl_mis++;
        tick();
        br_valid_e = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pc_f = '0; br_valid_e = 1'b0; pc_e = '0; target_e = '0;
        taken_e = 1'b0; pred_taken_e = 1'b0; pred_target_e = '0; clear_req = 1'b1;
        tick();
        tick();
        rst_n = 1'b1; clear_req = 1'b0;

        look(32'h100, 1'b0, 32'h0);
        counters();

        look(32'h40, 1'b0, 32'h0);
        br(32'h40, 32'h80, 1'b1, 1'b0, 32'h0);
        look(32'h40, 1'b1, 32'h80);

        br(32'h40, 32'h80, 1'b0, 1'b1, 32'h80);
        look(32'h40, 1'b0, 32'h80);
        br(32'h40, 32'h80, 1'b0, 1'b0, 32'h80);
        look(32'h40, 1'b0, 32'h80);
        br(32'h40, 32'h80, 1'b1, 1'b0, 32'h80);
        look(32'h40, 1'b0, 32'h80);

        br(32'h80, 32'h200, 1'b1, 1'b0, 32'h0);
        look(32'h40, 1'b0, 32'h0);
        look(32'h80, 1'b1, 32'h200);

        br(32'h104, 32'h400, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) br(32'h104, 32'h400, 1'b1, 1'b1, 32'h400);
        look(32'h104, 1'b1, 32'h400);
        br(32'h104, 32'h400, 1'b0, 1'b1, 32'h400);
        look(32'h104, 1'b1, 32'h400);
        br(32'h104, 32'h400, 1'b0, 1'b1, 32'h400);
        look(32'h104, 1'b0, 32'h400);

        br(32'h208, 32'h600, 1'b1, 1'b0, 32'h0);
        look(32'h208, 1'b1, 32'h600);
        counters();

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n_busy = 0;
        while (busy === 1'b1 && n_busy < 40) begin
            if (n_busy == 0) begin
                look(32'h208, 1'b0, 32'h600);
                br(32'h50, 32'h500, 1'b1, 1'b0, 32'h0);
            end else if (n_busy == 3) begin
                clear_req = 1'b1;
                tick();
                clear_req = 1'b0;
            end else begin
                tick();
            end
            n_busy++;
        end
        push("busy_cycles", 32'd16);
        chk(n_busy);
        look(32'h80, 1'b0, 32'h0);
        look(32'h104, 1'b0, 32'h0);
        look(32'h208, 1'b0, 32'h0);
        look(32'h50, 1'b0, 32'h0);
        counters();

        br(32'h50, 32'h500, 1'b1, 1'b0, 32'h0);
        look(32'h50, 1'b1, 32'h500);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0; clear_req = 1'b1;
        tick();
        rst_n = 1'b1; clear_req = 1'b0;
        mdl_br = 0; mdl_mis = 0;
        counters();
        look(32'h50, 1'b0, 32'h0);
        tick();
        counters();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
